// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 sequencer: FSM states, S-memory owner codes and default widths.
package arc4_pkg;

    localparam int DEF_KEY_W  = 24;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        INIT_GO, INIT_LO, INIT_HI,
        KSA_GO,  KSA_LO,  KSA_HI,
        PRGA_GO, PRGA_LO, PRGA_HI,
        FIN
    } seq_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INIT,
        OWN_KSA,
        OWN_PRGA
    } s_owner_t;

    // A sub-block keeps the memory port for its whole GO/LO/HI window.
    function automatic s_owner_t state_owner(input seq_state_t s);
        s_owner_t o;
        o = OWN_NONE;
        case (s)
            INIT_GO, INIT_LO, INIT_HI: o = OWN_INIT;
            KSA_GO,  KSA_LO,  KSA_HI:  o = OWN_KSA;
            PRGA_GO, PRGA_LO, PRGA_HI: o = OWN_PRGA;
            default:                   o = OWN_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/s_mem_mux.sv
// Combinational S-memory port arbiter: forwards the current owner's bundle, idles the port otherwise.
module s_mem_mux
    import arc4_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              rst,
    input  s_owner_t          owner,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic              ksa_wren,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren
);

    // No write may reach the memory while reset is asserted, whoever owns the port.
    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (owner)
            OWN_INIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            OWN_KSA: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            OWN_PRGA: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: ;
        endcase
        if (rst) begin
            s_wren = 1'b0;
        end
    end

endmodule

// File: rtl/arc4_seq.sv
// ARC4 top-level sequencer: runs init, ksa and prga in order over en/rdy and arbitrates the S-memory port.
module arc4_seq
    import arc4_pkg::*;
#(
    parameter int KEY_W   = DEF_KEY_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    output logic [KEY_W-1:0]  key_q,
    output logic              done,
    output logic              err,
    output logic              init_en,
    output logic              ksa_en,
    output logic              prga_en,
    input  logic              init_rdy,
    input  logic              ksa_rdy,
    input  logic              prga_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              init_wren,
    input  logic              ksa_wren,
    input  logic              prga_wren,
    output logic [DATA_W-1:0] s_rddata_out,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren,
    input  logic [DATA_W-1:0] s_rddata
);

    localparam int WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [WD_W-1:0] wdog;
    logic            busy;
    logic            stay_busy;
    logic            wd_hit;
    logic            init_en_nxt;
    logic            ksa_en_nxt;
    logic            prga_en_nxt;
    logic            done_nxt;

    assign rdy          = (state == IDLE);
    assign s_rddata_out = s_rddata;

    assign busy      = state inside {INIT_LO, INIT_HI, KSA_LO, KSA_HI, PRGA_LO, PRGA_HI};
    assign stay_busy = state_nxt inside {INIT_LO, INIT_HI, KSA_LO, KSA_HI, PRGA_LO, PRGA_HI};
    assign wd_hit    = (TIMEOUT != 0) && busy && (wdog == WD_W'(TIMEOUT - 1));

    // The watchdog only runs while a sub-block holds the handshake, so any move
    // into a GO state (or back to IDLE) restarts it from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            key_q   <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
            init_en <= 1'b0;
            ksa_en  <= 1'b0;
            prga_en <= 1'b0;
            wdog    <= '0;
        end else begin
            state   <= state_nxt;
            done    <= done_nxt;
            init_en <= init_en_nxt;
            ksa_en  <= ksa_en_nxt;
            prga_en <= prga_en_nxt;
            if (rdy && en) begin
                key_q <= key;
                err   <= 1'b0;
            end else if (wd_hit) begin
                err   <= 1'b1;
            end
            wdog <= (busy && stay_busy) ? wdog + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)        state_nxt = INIT_GO;
            INIT_GO: if (init_rdy)  state_nxt = INIT_LO;
            INIT_LO: if (!init_rdy) state_nxt = INIT_HI;
            INIT_HI: if (init_rdy)  state_nxt = KSA_GO;
            KSA_GO:  if (ksa_rdy)   state_nxt = KSA_LO;
            KSA_LO:  if (!ksa_rdy)  state_nxt = KSA_HI;
            KSA_HI:  if (ksa_rdy)   state_nxt = PRGA_GO;
            PRGA_GO: if (prga_rdy)  state_nxt = PRGA_LO;
            PRGA_LO: if (!prga_rdy) state_nxt = PRGA_HI;
            PRGA_HI: if (prga_rdy)  state_nxt = FIN;
            FIN:                    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
        if (wd_hit) begin
            state_nxt = IDLE;
        end
    end

    // Start pulses and done are derived from the chosen transition, so a
    // watchdog abort can never leak a start or a completion.
    always_comb begin
        init_en_nxt = 1'b0;
        ksa_en_nxt  = 1'b0;
        prga_en_nxt = 1'b0;
        done_nxt    = (state_nxt == FIN);
        case (state)
            INIT_GO: init_en_nxt = (state_nxt == INIT_LO);
            KSA_GO:  ksa_en_nxt  = (state_nxt == KSA_LO);
            PRGA_GO: prga_en_nxt = (state_nxt == PRGA_LO);
            default: ;
        endcase
    end

    s_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .rst         (rst),
        .owner       (state_owner(state)),
        .init_addr   (init_addr),
        .init_wrdata (init_wrdata),
        .init_wren   (init_wren),
        .ksa_addr    (ksa_addr),
        .ksa_wrdata  (ksa_wrdata),
        .ksa_wren    (ksa_wren),
        .prga_addr   (prga_addr),
        .prga_wrdata (prga_wrdata),
        .prga_wren   (prga_wren),
        .s_addr      (s_addr),
        .s_wrdata    (s_wrdata),
        .s_wren      (s_wren)
    );

endmodule

// File: doc/arc4_seq.md
Name: arc4_seq

Overview:
- Top-level sequencer for the ARC4 datapath. It drives the en/rdy handshake into the init, ksa and prga blocks, running them strictly in order.
- It owns the single S-memory port and grants it to whichever sub-block is currently active.
- On the ksa/prga en/rdy protocol it acts as the initiator; the sub-blocks are the responders.
- Upstream sees one en/rdy pair plus a done pulse and a sticky timeout error.

Parameters:
KEY_W, 24, key width forwarded to ksa/prga
ADDR_W, 8, S-memory address width
DATA_W, 8, S-memory data width
TIMEOUT, 1024, max cycles any sub-block may stay busy; 0 disables the watchdog

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en  in  1  upstream start request, sampled only when rdy=1
rdy  out  1  high when idle and able to accept en
key  in  KEY_W  key, latched on an accepted en
key_q  out  KEY_W  latched key to ksa/prga
done  out  1  one-cycle pulse when prga completes
err  out  1  sticky watchdog flag, cleared on next accepted en
init_en/ksa_en/prga_en  out  1 each  one-cycle start pulses to sub-blocks
init_rdy/ksa_rdy/prga_rdy  in  1 each  sub-block ready
init_addr/ksa_addr/prga_addr  in  ADDR_W each  sub-block S address
init_wrdata/ksa_wrdata/prga_wrdata  in  DATA_W each  sub-block write data
init_wren/ksa_wren/prga_wren  in  1 each  sub-block write enable
s_rddata_out  out  DATA_W  s_rddata broadcast to all sub-blocks
s_addr  out  ADDR_W  S-memory address
s_wrdata  out  DATA_W  S-memory write data
s_wren  out  1  S-memory write enable
s_rddata  in  DATA_W  S-memory read data

Behaviour:
- States: IDLE, INIT_GO, INIT_LO, INIT_HI, KSA_GO, KSA_LO, KSA_HI, PRGA_GO, PRGA_LO, PRGA_HI, FIN.
- Reset: state IDLE, key_q=0, err=0, done=0, all *_en=0, watchdog=0. rdy = (state==IDLE), so rdy=1 in the first cycle after reset.
- IDLE: en=1 latches key into key_q, clears err and moves to INIT_GO. en=0 stays in IDLE.
- Starting a sub-block, X in {INIT, KSA, PRGA}:
  - X_GO waits for X_rdy=1, then asserts X_en for exactly one cycle and moves to X_LO. X_en is registered and is never high for two consecutive cycles.
  - X_LO waits for X_rdy=0, which acknowledges the start, then moves to X_HI.
  - X_HI waits for X_rdy=1, which signals completion.
  - Completion moves INIT to KSA_GO, KSA to PRGA_GO, and PRGA to FIN.
- FIN: done=1 for one cycle, then IDLE. rdy is low from the cycle after en is accepted until the cycle after FIN.
- en while rdy=0 is ignored and never queued. key changes while busy have no effect.
- Watchdog:
  - Counts cycles spent in X_LO plus X_HI and is cleared on entering each X_GO.
  - When TIMEOUT≠0 and the count reaches TIMEOUT: err=1, state goes to IDLE, no done pulse, and no *_en is issued that cycle.
  - Counter width is $clog2(TIMEOUT+1).
- Memory mux (combinational):
  - The owner is INIT in INIT_*, KSA in KSA_*, PRGA in PRGA_*, otherwise none.
  - Owner's addr/wrdata/wren go to s_addr/s_wrdata/s_wren.
  - With no owner: s_addr=0, s_wrdata=0, s_wren=0.
  - Non-owner wren is ignored.
  - s_wren is additionally gated by !rst, so it is 0 in any cycle where rst=1.
  - s_rddata_out = s_rddata always.
- Reset mid-operation: at the next edge, state goes to IDLE and all en outputs go low. No done pulse. err goes to 0.
- Simultaneous rst and en: rst wins and en is dropped.

Decomposition:
- Package arc4_pkg holds:
  - the state enum (seq_state_t)
  - the owner enum (s_owner_t: OWN_NONE, OWN_INIT, OWN_KSA, OWN_PRGA)
  - localparams for default KEY_W, ADDR_W, DATA_W
- One sub-module, s_mem_mux: takes s_owner_t plus the three port bundles and rst, and produces the S-memory port. It is purely combinational.
- The FSM and watchdog stay in arc4_seq.

Test Plan:
1. Reset, then en=1 for one cycle with key=24'h035F3C. Responder models take 256/768/10 cycles. Required: key_q=035F3C, exactly one pulse each on init_en, ksa_en and prga_en, in that order, done pulses once, rdy returns to 1, err=0.
2. Ownership check. During the INIT phase, drive ksa_wren=1 with ksa_addr=8'hAA. Required: s_wren follows init_wren only and s_addr never equals AA. In the KSA phase, ksa_addr=8'h11 with wren=1 must appear on s_addr/s_wren.
3. en=1 pulsed during the KSA phase with a different key. Required: ignored, key_q unchanged, exactly one done pulse.
4. TIMEOUT=16 and the ksa model never raises rdy. Required: err=1 exactly 16 cycles after entering KSA_LO, state returns to IDLE, rdy=1, no prga_en, no done. A following accepted en clears err.
5. Assert rst for one cycle mid-PRGA. Required: s_wren=0 in the rst cycle, prga_en=0, rdy=1 next cycle, no done pulse.
6. Hold init_rdy=0 for 5 cycles after start. Required: init_en is not asserted until the cycle after init_rdy rises.
